// File: rtl/issue_queue_integer_pkg.sv
// Shared types for the integer issue queue: payload widths, ALU opcodes, entry layout,
// and the operand wakeup helper used by every slot.
package issue_queue_integer_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH  = 6;
  localparam int OPC_WIDTH  = 4;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [TAG_WIDTH-1:0]  tag_t;
  typedef logic [OPC_WIDTH-1:0]  opc_t;

  localparam opc_t OP_ADD  = 4'd0;
  localparam opc_t OP_SUB  = 4'd1;
  localparam opc_t OP_AND  = 4'd2;
  localparam opc_t OP_OR   = 4'd3;
  localparam opc_t OP_XOR  = 4'd4;
  localparam opc_t OP_SLL  = 4'd5;
  localparam opc_t OP_SRL  = 4'd6;
  localparam opc_t OP_SRA  = 4'd7;
  localparam opc_t OP_SLT  = 4'd8;
  localparam opc_t OP_SLTU = 4'd9;

  typedef struct packed {
    logic  pend;
    tag_t  tag;
    data_t data;
  } opnd_t;

  typedef struct packed {
    logic  valid;
    opc_t  opcode;
    tag_t  rd_tag;
    opnd_t rs1;
    opnd_t rs2;
  } iq_entry_t;

  // A pending operand whose producer tag is on the CDB takes the broadcast value.
  function automatic opnd_t opnd_wake(opnd_t o, logic cdb_valid, tag_t cdb_tag, data_t cdb_data);
    opnd_t r;
    r = o;
    if (cdb_valid && o.pend && (o.tag == cdb_tag)) begin
      r.pend = 1'b0;
      r.data = cdb_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/issue_queue_integer_if.sv
// Dispatch, CDB broadcast and issue signals of the integer issue queue.
// master drives dispatch/CDB/issue_ready; slave is the queue itself.
interface issue_queue_integer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
);

  logic                  dispatch_en_integer;
  logic [3:0]            dispatch_opcode;
  logic [TAG_WIDTH-1:0]  dispatch_rd_tag;
  logic [DATA_WIDTH-1:0] dispatch_rs1_data;
  logic [DATA_WIDTH-1:0] dispatch_rs2_data;
  logic [TAG_WIDTH-1:0]  dispatch_rs1_tag;
  logic [TAG_WIDTH-1:0]  dispatch_rs2_tag;
  logic                  dispatch_rs1_valid;
  logic                  dispatch_rs2_valid;

  logic [TAG_WIDTH-1:0]  CDB_tag;
  logic                  CDB_valid;
  logic [DATA_WIDTH-1:0] CDB_data;

  logic                  issue_ready;
  logic                  issueque_full_integer;
  logic                  issue_valid;
  logic [3:0]            issue_opcode;
  logic [TAG_WIDTH-1:0]  issue_rd_tag;
  logic [DATA_WIDTH-1:0] issue_rs1_data;
  logic [DATA_WIDTH-1:0] issue_rs2_data;

  modport master (
    output dispatch_en_integer, dispatch_opcode, dispatch_rd_tag,
           dispatch_rs1_data, dispatch_rs2_data, dispatch_rs1_tag, dispatch_rs2_tag,
           dispatch_rs1_valid, dispatch_rs2_valid,
           CDB_tag, CDB_valid, CDB_data, issue_ready,
    input  issueque_full_integer, issue_valid, issue_opcode, issue_rd_tag,
           issue_rs1_data, issue_rs2_data
  );

  modport slave (
    input  dispatch_en_integer, dispatch_opcode, dispatch_rd_tag,
           dispatch_rs1_data, dispatch_rs2_data, dispatch_rs1_tag, dispatch_rs2_tag,
           dispatch_rs1_valid, dispatch_rs2_valid,
           CDB_tag, CDB_valid, CDB_data, issue_ready,
    output issueque_full_integer, issue_valid, issue_opcode, issue_rd_tag,
           issue_rs1_data, issue_rs2_data
  );

endinterface

// File: rtl/iq_entry.sv
// One issue-queue slot: selects dispatch, upper-neighbour shift or hold, then applies CDB wakeup.
// Registered, one-cycle update; wakeup on the shifted/dispatched value covers bypass and shift-wake.
module iq_entry
  import issue_queue_integer_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load,
  input  iq_entry_t load_ent,
  input  logic      shift,
  input  iq_entry_t upper_ent,
  input  logic      cdb_valid,
  input  tag_t      cdb_tag,
  input  data_t     cdb_data,
  output iq_entry_t ent
);

  iq_entry_t src;
  iq_entry_t nxt;

  always_comb begin
    src = ent;
    if (load) begin
      src = load_ent;
    end else if (shift) begin
      src = upper_ent;
    end
    nxt = src;
    if (src.valid) begin
      nxt.rs1 = opnd_wake(src.rs1, cdb_valid, cdb_tag, cdb_data);
      nxt.rs2 = opnd_wake(src.rs2, cdb_valid, cdb_tag, cdb_data);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent <= '0;
    end else begin
      ent <= nxt;
    end
  end

endmodule

// File: rtl/issue_queue_integer.sv
// Age-ordered integer issue queue: slot 0 oldest, lowest ready slot issued, younger slots compact.
// Issue is combinational from state; full reflects registered count only, so dispatch stalls while full.
module issue_queue_integer #(
  parameter int DATA_WIDTH = issue_queue_integer_pkg::DATA_WIDTH,
  parameter int TAG_WIDTH  = issue_queue_integer_pkg::TAG_WIDTH,
  parameter int DEPTH      = 4
) (
  input logic                   clk,
  input logic                   reset,
  issue_queue_integer_if.slave  iq
);

  import issue_queue_integer_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  iq_entry_t        ent_q     [DEPTH];
  iq_entry_t        upper_ent [DEPTH];
  iq_entry_t        disp_ent;
  iq_entry_t        sel_ent;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] sel_oh;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] shift;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_after;
  logic             sel_vld;
  logic             full;
  logic             accept;
  logic             fire;
  tag_t             cdb_tag;
  data_t            cdb_data;

  assign full        = (count == CW'(DEPTH));
  assign accept      = iq.dispatch_en_integer && !full;
  assign fire        = sel_vld && iq.issue_ready;
  assign count_after = count - CW'(fire);
  assign cdb_tag     = tag_t'(iq.CDB_tag);
  assign cdb_data    = data_t'(iq.CDB_data);

  always_comb begin
    disp_ent            = '0;
    disp_ent.valid      = 1'b1;
    disp_ent.opcode     = iq.dispatch_opcode;
    disp_ent.rd_tag     = tag_t'(iq.dispatch_rd_tag);
    disp_ent.rs1.pend   = iq.dispatch_rs1_valid;
    disp_ent.rs1.tag    = tag_t'(iq.dispatch_rs1_tag);
    disp_ent.rs1.data   = data_t'(iq.dispatch_rs1_data);
    disp_ent.rs2.pend   = iq.dispatch_rs2_valid;
    disp_ent.rs2.tag    = tag_t'(iq.dispatch_rs2_tag);
    disp_ent.rs2.data   = data_t'(iq.dispatch_rs2_data);
  end

  // Lowest set ready bit is the oldest issuable entry.
  assign sel_oh  = ready & (~ready + DEPTH'(1));
  assign sel_vld = |ready;

  always_comb begin
    logic above_sel;
    sel_ent   = '0;
    shift     = '0;
    above_sel = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) begin
        sel_ent = ent_q[i];
      end
      above_sel = above_sel | sel_oh[i];
      shift[i]  = fire && above_sel;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign ready[i] = ent_q[i].valid && !ent_q[i].rs1.pend && !ent_q[i].rs2.pend;
    // New entry lands after the compaction caused by a same-cycle issue.
    assign load[i]  = accept && (count_after == CW'(i));

    if (i == DEPTH - 1) begin : g_top
      assign upper_ent[i] = '0;
    end else begin : g_mid
      assign upper_ent[i] = ent_q[i+1];
    end

    iq_entry u_entry (
      .clk       (clk),
      .reset     (reset),
      .load      (load[i]),
      .load_ent  (disp_ent),
      .shift     (shift[i]),
      .upper_ent (upper_ent[i]),
      .cdb_valid (iq.CDB_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .ent       (ent_q[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count + CW'(accept) - CW'(fire);
    end
  end

  always_comb begin
    iq.issueque_full_integer = full;
    iq.issue_valid           = sel_vld;
    iq.issue_opcode          = '0;
    iq.issue_rd_tag          = '0;
    iq.issue_rs1_data        = '0;
    iq.issue_rs2_data        = '0;
    if (sel_vld) begin
      iq.issue_opcode   = sel_ent.opcode;
      iq.issue_rd_tag   = TAG_WIDTH'(sel_ent.rd_tag);
      iq.issue_rs1_data = DATA_WIDTH'(sel_ent.rs1.data);
      iq.issue_rs2_data = DATA_WIDTH'(sel_ent.rs2.data);
    end
  end

endmodule
